// File: rtl/issue_ctrl_pkg.sv
// Shared decode codes and issue-controller types.
// Instruction-type and opcode codes mirror the decoder's shared definitions;
// the latency defaults feed the issue_ctrl / mul_scoreboard parameters.
package issue_ctrl_pkg;

   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned OPCODE_W  = 7;
   localparam int unsigned TYPE_W    = 3;

   localparam int unsigned MUL_LATENCY_DEF = 4;
   localparam int unsigned ALU_LATENCY_DEF = 2;

   localparam logic [TYPE_W-1:0] INSTR_TYPE_ALU    = 3'd0;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_LOAD   = 3'd1;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_STORE  = 3'd2;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_BRANCH = 3'd3;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_JUMP   = 3'd4;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_MUL    = 3'd5;
   localparam logic [TYPE_W-1:0] INSTR_TYPE_NOP    = 3'd6;

   localparam logic [OPCODE_W-1:0] OPCODE_ALU     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OPCODE_ALU_IMM = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OPCODE_LOAD    = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OPCODE_STORE   = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OPCODE_BRANCH  = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OPCODE_JUMP    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OPCODE_LUI     = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OPCODE_AUIPC   = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OPCODE_NOP     = 7'b0000000;

   // One in-flight MUL; valid is clear for rd = x0 so it never hazards.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sb_entry_t;

   typedef struct packed {
      logic rs1;
      logic rs2;
   } src_use_t;

   // Which source registers an opcode actually reads.
   function automatic src_use_t src_use(input logic [OPCODE_W-1:0] opcode);
      src_use_t u;
      u = '0;
      case (opcode)
         OPCODE_ALU, OPCODE_BRANCH, OPCODE_STORE: u = '{rs1: 1'b1, rs2: 1'b1};
         OPCODE_ALU_IMM, OPCODE_LOAD:             u = '{rs1: 1'b1, rs2: 1'b0};
         default:                                 u = '0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/mul_scoreboard.sv
// Age-ordered shift register of in-flight MULs.
// Slot k holds the entry of age k+1; every slot shifts each cycle, so the
// last slot (age DEPTH) is the retiring entry that owns the write port.
// Ports: clk, reset (async high), push/push_rd (MUL issuing this cycle),
//        ent[] (per-entry valid/rd, age = index+1), ret_valid/ret_rd.
module mul_scoreboard
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = MUL_LATENCY_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [REG_W-1:0] push_rd,
   output sb_entry_t        ent [DEPTH],
   output logic             ret_valid,
   output logic [REG_W-1:0] ret_rd
);

   // Shift every cycle; a retiring slot frees and refills on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) ent[k] <= '0;
      end else begin
         ent[0].valid <= push && (push_rd != '0);
         ent[0].rd    <= push ? push_rd : '0;
         for (int unsigned k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      end
   end

   assign ret_valid = ent[DEPTH-1].valid;
   assign ret_rd    = ent[DEPTH-1].rd;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: holds decoded instructions until RAW, WAW and
// writeback-port hazards against in-flight MULs clear, and arbitrates the
// single register-file write port between ALU and MUL timing.
// Ports: clk, reset (async high); decoder in_* fields, exe_ready, flush;
//        in_ready/issue_valid/issue_is_mul (combinational issue decision),
//        stall_raw/waw/wb cause flags, mul_wb_valid/mul_wb_rd writeback.
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEF,
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] in_opcode,
   input  logic [TYPE_W-1:0]   in_instr_type,
   input  logic [REG_W-1:0]    in_rs1,
   input  logic [REG_W-1:0]    in_rs2,
   input  logic [REG_W-1:0]    in_rd,
   input  logic                exe_ready,
   input  logic                flush,
   output logic                in_ready,
   output logic                issue_valid,
   output logic                issue_is_mul,
   output logic                stall_raw,
   output logic                stall_waw,
   output logic                stall_wb,
   output logic                mul_wb_valid,
   output logic [REG_W-1:0]    mul_wb_rd
);

   // Slot whose MUL writes back in the same cycle a non-MUL issued now would.
   localparam int unsigned WB_IDX = MUL_LATENCY - ALU_LATENCY - 1;

   sb_entry_t ent [MUL_LATENCY];
   src_use_t  use_src;
   logic      is_mul;
   logic      writes;
   logic      raw;
   logic      waw_hit;
   logic      waw;
   logic      wb;
   logic      live;

   mul_scoreboard #(.DEPTH(MUL_LATENCY)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .push      (issue_is_mul),
      .push_rd   (in_rd),
      .ent       (ent),
      .ret_valid (mul_wb_valid),
      .ret_rd    (mul_wb_rd)
   );

   // Hazard detection against the scoreboard.
   always_comb begin
      use_src = src_use(in_opcode);
      is_mul  = (in_instr_type == INSTR_TYPE_MUL);
      writes  = ((in_instr_type == INSTR_TYPE_ALU) ||
                 (in_instr_type == INSTR_TYPE_LOAD) || is_mul) && (in_rd != '0);
      raw     = 1'b0;
      waw_hit = 1'b0;
      // The writeback-cycle slot is forwarded by the register file: skip it.
      for (int unsigned k = 0; k < MUL_LATENCY - 1; k++) begin
         if (ent[k].valid) begin
            if (use_src.rs1 && (in_rs1 != '0) && (in_rs1 == ent[k].rd)) raw = 1'b1;
            if (use_src.rs2 && (in_rs2 != '0) && (in_rs2 == ent[k].rd)) raw = 1'b1;
         end
      end
      for (int unsigned k = 0; k <= WB_IDX; k++) begin
         if (ent[k].valid && (in_rd == ent[k].rd)) waw_hit = 1'b1;
      end
      waw  = writes && !is_mul && waw_hit;
      wb   = writes && !is_mul && ent[WB_IDX].valid;
      live = in_valid && !flush && !reset;
   end

   assign stall_raw    = live && raw;
   assign stall_waw    = live && waw;
   assign stall_wb     = live && wb;
   assign in_ready     = live && exe_ready && !raw && !waw && !wb;
   assign issue_valid  = in_ready;
   assign issue_is_mul = is_mul && issue_valid;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: per-cycle issue/stall expectations,
// plus a queue of expected MUL writebacks (cycle, rd) popped on mul_wb_valid.
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   localparam int MUL_LAT = 4;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [6:0] in_opcode;
   logic [2:0] in_instr_type;
   logic [4:0] in_rs1, in_rs2, in_rd;
   logic       exe_ready, flush;
   logic       in_ready, issue_valid, issue_is_mul;
   logic       stall_raw, stall_waw, stall_wb;
   logic       mul_wb_valid;
   logic [4:0] mul_wb_rd;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int         exp_cyc [$];
   logic [4:0] exp_rd  [$];

   issue_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_opcode     (in_opcode),
      .in_instr_type (in_instr_type),
      .in_rs1        (in_rs1),
      .in_rs2        (in_rs2),
      .in_rd         (in_rd),
      .exe_ready     (exe_ready),
      .flush         (flush),
      .in_ready      (in_ready),
      .issue_valid   (issue_valid),
      .issue_is_mul  (issue_is_mul),
      .stall_raw     (stall_raw),
      .stall_waw     (stall_waw),
      .stall_wb      (stall_wb),
      .mul_wb_valid  (mul_wb_valid),
      .mul_wb_rd     (mul_wb_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Writeback monitor: every MUL result must appear exactly when expected.
   always @(negedge clk) begin
      if (!reset) begin
         if (mul_wb_valid) begin
            if (exp_cyc.size() == 0) check("wb_extra", 32'd1, 32'd0);
            else begin
               check("wb_cycle", cyc, exp_cyc.pop_front());
               check("wb_rd", {27'd0, mul_wb_rd}, {27'd0, exp_rd.pop_front()});
            end
         end else if (exp_cyc.size() != 0 && exp_cyc[0] <= cyc) begin
            check("wb_missing", 32'd0, 32'd1);
            void'(exp_cyc.pop_front());
            void'(exp_rd.pop_front());
         end
      end
   end

   // Present one instruction for one cycle and check the issue decision.
   task automatic present(input logic v, input logic [2:0] ty, input logic [6:0] op,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic ex, input logic fl,
                          input logic e_rdy, input logic e_raw, input logic e_waw,
                          input logic e_wb);
      in_valid = v; in_instr_type = ty; in_opcode = op;
      in_rs1 = s1; in_rs2 = s2; in_rd = d; exe_ready = ex; flush = fl;
      @(negedge clk);
      check("in_ready", in_ready, e_rdy);
      check("issue_valid", issue_valid, e_rdy);
      check("issue_is_mul", issue_is_mul, e_rdy && (ty == INSTR_TYPE_MUL));
      check("stall_raw", stall_raw, e_raw);
      check("stall_waw", stall_waw, e_waw);
      check("stall_wb", stall_wb, e_wb);
      if (e_rdy && ty == INSTR_TYPE_MUL && d != 5'd0) begin
         exp_cyc.push_back(cyc + MUL_LAT);
         exp_rd.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         present(1'b0, INSTR_TYPE_NOP, OPCODE_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mul(input logic [4:0] d, input logic ex, input logic e_rdy);
      present(1'b1, INSTR_TYPE_MUL, OPCODE_ALU, 5'd20, 5'd21, d, ex, 1'b0,
              e_rdy, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b1; in_instr_type = INSTR_TYPE_MUL; in_opcode = OPCODE_ALU;
      in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; exe_ready = 1'b1; flush = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_wb_valid", mul_wb_valid, 1'b0);
      check("rst_wb_rd", {27'd0, mul_wb_rd}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // RAW: add x6,x5,x1 behind MUL x5.
      mul(5'd5, 1'b1, 1'b1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 0, 1, 0, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 0, 1, 0, 1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 0, 1, 0, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1, 0, 0, 0);
      idle(5);

      // WB port: addi x8 presented two cycles after MUL x7.
      mul(5'd7, 1'b1, 1'b1);
      idle(1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 0, 0, 0, 1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1, 0, 0, 0);
      idle(5);

      // WAW: addi x9 behind MUL x9.
      mul(5'd9, 1'b1, 1'b1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 0, 0, 1, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 0, 0, 1, 1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1, 0, 0, 0);
      idle(5);

      // x0: MUL x0 never hazards; add x1,x0,x0 and addi x1,x0 issue freely.
      mul(5'd0, 1'b1, 1'b1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1, 0, 0, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1, 0, 0, 0);
      idle(4);

      // Flush: clean addi squashed, then a hazarding one squashed with no flags.
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd4, 5'd0, 5'd3, 1'b1, 1'b1, 0, 0, 0, 0);
      mul(5'd10, 1'b1, 1'b1);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 0, 0, 0, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 0, 1, 0, 1);
      // Flags are independent of exe_ready.
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd10, 5'd0, 5'd11, 1'b0, 1'b0, 0, 1, 0, 0);
      present(1'b1, INSTR_TYPE_ALU, OPCODE_ALU_IMM, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1, 0, 0, 0);
      idle(5);

      // Back-to-back MULs x1..x6: full scoreboard, in-order retirement.
      for (int i = 1; i <= 6; i++) mul(5'(i), 1'b1, 1'b1);
      idle(5);

      // exe_ready low for one cycle delays the second MUL's issue only.
      mul(5'd12, 1'b1, 1'b1);
      mul(5'd13, 1'b0, 1'b0);
      mul(5'd13, 1'b1, 1'b1);
      mul(5'd14, 1'b1, 1'b1);
      idle(6);

      // Reset with three MULs in flight discards their results.
      mul(5'd15, 1'b1, 1'b1);
      mul(5'd16, 1'b1, 1'b1);
      mul(5'd17, 1'b1, 1'b1);
      in_valid = 1'b1; exe_ready = 1'b1;
      #2 reset = 1'b1;
      exp_cyc.delete();
      exp_rd.delete();
      @(negedge clk);
      check("midrst_wb_valid", mul_wb_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         present(1'b0, INSTR_TYPE_NOP, OPCODE_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 0, 0, 0, 0);
         check("postrst_wb_valid", mul_wb_valid, 1'b0);
      end

      check("wb_queue_empty", exp_cyc.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
